// File: rtl/serial_slave_mem_if.sv
// Bit-serial bus between an interconnect master port and one serial_slave_mem.
// cfg_err is present only when SERIAL_SLAVE_PARITY_EN is defined.
interface serial_slave_mem_if;
  logic control;
  logic wD;
  logic valid;
  logic last;
  logic rD;
  logic rvalid;
  logic ready;
`ifdef SERIAL_SLAVE_PARITY_EN
  logic cfg_err;

  modport slave  (input control, wD, valid, last, output rD, rvalid, ready, cfg_err);
  modport master (output control, wD, valid, last, input rD, rvalid, ready, cfg_err);
`else
  modport slave  (input control, wD, valid, last, output rD, rvalid, ready);
  modport master (output control, wD, valid, last, input rD, rvalid, ready);
`endif
endinterface

// File: rtl/serial_slave_mem.sv
// Serial-bus RAM slave: config frame on control, single/burst word transfers on rD/wD.
// Optional even-parity frame check and cfg_err pulse: define SERIAL_SLAVE_PARITY_EN.
module serial_slave_mem #(
  parameter int  ADDR_DEPTH = 2048,
  parameter int  DATA_WIDTH = 32,
  parameter int  SLAVES     = 4,
  localparam int ID_W       = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  localparam int ADDR_W     = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   i_slave_id,
  serial_slave_mem_if.slave bus
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CFG_LEN = 3 + ID_W + 2 + ADDR_W + PAR_W;
  localparam int CNT_MAX = (CFG_LEN > DATA_WIDTH) ? CFG_LEN : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_CFG_END   = CNT_W'(CFG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_WORD_END  = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_DECODE, S_RFETCH, S_RSHIFT, S_WRITE
  } state_t;

  function automatic logic f_even_parity_ok(input logic [CFG_LEN-1:0] frame);
    return ~(^frame);
  endfunction

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(ADDR_DEPTH - 1)) return {ADDR_W{1'b0}};
    else return a + ADDR_W'(1);
  endfunction

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CFG_LEN-1:0]      r_cfg;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_burst;
  logic                    r_last;
  logic [DATA_WIDTH-1:0]   r_rshift;
  logic [DATA_WIDTH-2:0]   r_wshift;
  logic                    r_rd;
  logic                    r_rvalid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_mem [ADDR_DEPTH];

  logic [2:0]              w_start;
  logic [ID_W-1:0]         w_id;
  logic                    w_rw;
  logic                    w_burst;
  logic [ADDR_W-1:0]       w_addr;
  logic                    w_sid_ok;
  logic                    w_addr_ok;
  logic                    w_par_ok;
  logic                    w_accept;
  logic                    w_rd_word_done;
  logic                    w_rd_stop;
  logic                    w_wr_word_done;
  logic                    w_wr_stop;
  logic [DATA_WIDTH-1:0]   w_wword;

  // Frame fields, MSB first: start | id | rw | burst | address [| parity]
  assign w_start   = r_cfg[CFG_LEN-1 -: 3];
  assign w_id      = r_cfg[CFG_LEN-4 -: ID_W];
  assign w_rw      = r_cfg[CFG_LEN-4-ID_W];
  assign w_burst   = r_cfg[CFG_LEN-5-ID_W];
  assign w_addr    = r_cfg[PAR_W +: ADDR_W];

  assign w_sid_ok  = (w_start == 3'b111) && (w_id == i_slave_id);
  assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W + 1)'(ADDR_DEPTH));
`ifdef SERIAL_SLAVE_PARITY_EN
  assign w_par_ok  = f_even_parity_ok(r_cfg);
`else
  assign w_par_ok  = 1'b1;
`endif
  assign w_accept  = w_sid_ok && w_addr_ok && w_par_ok;

  assign w_rd_word_done = (r_state == S_RSHIFT) && (r_cnt == CNT_WORD_LAST);
  assign w_rd_stop      = !r_burst || r_last || bus.last;
  assign w_wr_word_done = (r_state == S_WRITE) && bus.valid && (r_cnt == CNT_WORD_LAST);
  assign w_wr_stop      = !r_burst || bus.last;
  assign w_wword        = {r_wshift, bus.wD};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.control) w_next_state = S_CONFIG; else w_next_state = S_IDLE;
      S_CONFIG: if (r_cnt == CNT_CFG_END) w_next_state = S_DECODE; else w_next_state = S_CONFIG;
      S_DECODE: begin
        if (!w_accept) w_next_state = S_IDLE;
        else if (w_rw) w_next_state = S_WRITE;
        else           w_next_state = S_RFETCH;
      end
      S_RFETCH: w_next_state = S_RSHIFT;
      S_RSHIFT: begin
        // A continuing burst refetches straight off the last bit, giving a one-cycle gap.
        if (r_cnt == CNT_WORD_END) w_next_state = S_IDLE;
        else if (w_rd_word_done && !w_rd_stop) w_next_state = S_RFETCH;
        else w_next_state = S_RSHIFT;
      end
      S_WRITE:  if (w_wr_word_done && w_wr_stop) w_next_state = S_IDLE; else w_next_state = S_WRITE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Frame capture, counters, shift registers and registered bus outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cfg    <= {CFG_LEN{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_addr   <= {ADDR_W{1'b0}};
      r_burst  <= 1'b0;
      r_last   <= 1'b0;
      r_rshift <= {DATA_WIDTH{1'b0}};
      r_wshift <= {(DATA_WIDTH - 1){1'b0}};
      r_rd     <= 1'b0;
      r_rvalid <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_rd     <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cfg <= {r_cfg[CFG_LEN-2:0], bus.control};
          r_cnt <= bus.control ? CNT_W'(1) : {CNT_W{1'b0}};
        end
        S_CONFIG: begin
          r_cfg <= {r_cfg[CFG_LEN-2:0], bus.control};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DECODE: begin
          r_cnt  <= {CNT_W{1'b0}};
          r_last <= 1'b0;
          if (w_accept) begin
            r_burst <= w_burst;
            r_addr  <= w_addr;
            r_ready <= 1'b0;
          end
        end
        S_RFETCH: begin
          r_rshift <= r_mem[r_addr];
          r_cnt    <= {CNT_W{1'b0}};
          if (bus.last) r_last <= 1'b1;
        end
        S_RSHIFT: begin
          if (bus.last) r_last <= 1'b1;
          if (r_cnt == CNT_WORD_END) begin
            r_ready <= 1'b1;
          end else begin
            r_rd     <= r_rshift[DATA_WIDTH-1];
            r_rvalid <= 1'b1;
            r_rshift <= {r_rshift[DATA_WIDTH-2:0], 1'b0};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_rd_word_done && !w_rd_stop) r_addr <= f_next_addr(r_addr);
          end
        end
        S_WRITE: begin
          if (bus.valid) begin
            r_wshift <= w_wword[DATA_WIDTH-2:0];
            if (r_cnt == CNT_WORD_LAST) begin
              r_cnt <= {CNT_W{1'b0}};
              if (w_wr_stop) r_ready <= 1'b1;
              else           r_addr  <= f_next_addr(r_addr);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // RAM array carries no reset so it can map onto block memory
  always_ff @(posedge clk) begin
    if (w_wr_word_done) r_mem[r_addr] <= w_wword;
  end

`ifdef SERIAL_SLAVE_PARITY_EN
  logic r_cfg_err;

  // One-cycle error pulse for a frame addressed to us that fails parity
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cfg_err <= 1'b0;
    else         r_cfg_err <= (r_state == S_DECODE) && w_sid_ok && !w_par_ok;
  end

  assign bus.cfg_err = r_cfg_err;
`endif

  assign bus.rD     = r_rd;
  assign bus.rvalid = r_rvalid;
  assign bus.ready  = r_ready;

endmodule

// File: tb/tb_serial_slave_mem.sv
// Randomised scoreboard bench for serial_slave_mem (8-bit words, 16 deep, slave_id 2).
// Parity checks are compiled in when SERIAL_SLAVE_PARITY_EN is defined.
module tb_serial_slave_mem;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int CFG_LEN = 12;
  logic flip_parity = 1'b0;
`else
  localparam int CFG_LEN = 11;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] slave_id = 2'd2;

  serial_slave_mem_if bus();

  serial_slave_mem #(.ADDR_DEPTH(DEPTH), .DATA_WIDTH(DW), .SLAVES(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_slave_id (slave_id),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wbuf [DEPTH];
  logic [7:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: assemble rD bits into words and compare against the scoreboard queue
  initial begin
    logic [7:0] mon_sh;
    logic [7:0] e;
    int         mon_nb;
    mon_nb = 0;
    mon_sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_nb = 0;
      end else if (bus.rvalid) begin
        mon_sh = {mon_sh[6:0], bus.rD};
        mon_nb++;
        if (mon_nb == DW) begin
          mon_nb = 0;
          check("read word expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("read word", mon_sh, e);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [2:0] st, input logic [1:0] id, input logic rw,
                            input logic burst, input logic [3:0] addr);
    logic [CFG_LEN-1:0] f;
`ifdef SERIAL_SLAVE_PARITY_EN
    f    = {st, id, rw, burst, addr, 1'b0};
    f[0] = (^f) ^ flip_parity;
`else
    f = {st, id, rw, burst, addr};
`endif
    for (int i = CFG_LEN - 1; i >= 0; i--) begin
      bus.control = f[i];
      bus.valid   = 1'($urandom);
      bus.wD      = 1'($urandom);
      @(negedge clk);
    end
    bus.control = 1'b0;
    bus.valid   = 1'b0;
    bus.wD      = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic burst, input int n,
                          input int stall_at, input int stall_len, input bit rnd_stall);
    int t;
    int gi;
    int stalls;
    bit final_bit;
    send_frame(3'b111, 2'd2, 1'b1, burst, addr);
    t = 0;
    while (bus.ready && t < 8) begin @(negedge clk); t++; end
    check("write frame accepted", bus.ready, 0);
    gi = 0;
    for (int w = 0; w < n; w++) begin
      for (int b = DW - 1; b >= 0; b--) begin
        if (gi == stall_at) stalls = stall_len;
        else if (rnd_stall && $urandom_range(0, 7) == 0) stalls = $urandom_range(1, 3);
        else stalls = 0;
        repeat (stalls) begin
          bus.valid   = 1'b0;
          bus.wD      = 1'($urandom);
          bus.last    = 1'($urandom);
          bus.control = 1'($urandom);
          @(negedge clk);
        end
        final_bit   = (w == n - 1) && (b == 0);
        bus.valid   = 1'b1;
        bus.wD      = wbuf[w][b];
        bus.last    = final_bit ? 1'b1 : ((b == 0) ? 1'b0 : 1'($urandom));
        bus.control = final_bit ? 1'b0 : 1'($urandom);
        @(negedge clk);
        gi++;
      end
    end
    bus.valid   = 1'b0;
    bus.last    = 1'b0;
    bus.control = 1'b0;
    check("write ready return", bus.ready, 1);
    for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % DEPTH] = wbuf[i];
  endtask

  task automatic do_read(input logic [3:0] addr, input logic burst, input int n, input int last_k);
    int lat;
    int hc;
    int gaps;
    int t;
    bit pulsed;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(addr) + i) % DEPTH]);
    send_frame(3'b111, 2'd2, 1'b0, burst, addr);
    lat = 1;
    while (!bus.rvalid && lat < 10) begin @(negedge clk); lat++; end
    check("read first-bit latency", lat, 4);
    hc = 0; gaps = 0; t = 0; pulsed = 1'b0;
    while (!bus.ready && t < 200) begin
      if (bus.rvalid) hc++;
      else gaps++;
      if (burst && !pulsed && hc == (n - 1) * DW + last_k) begin
        bus.last = 1'b1;
        pulsed   = 1'b1;
      end else begin
        bus.last = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    bus.last = 1'b0;
    check("read ready return", bus.ready, 1);
    check("read rvalid cycles", hc, n * DW);
    check("read word gaps", gaps, n - 1);
  endtask

  task automatic do_reject(input logic [2:0] st, input logic [1:0] id, input logic rw, input logic [3:0] addr);
    bit bad;
    send_frame(st, id, rw, 1'b0, addr);
    bad = 1'b0;
    repeat (8) begin
      if (!bus.ready || bus.rvalid) bad = 1'b1;
      @(negedge clk);
    end
    check("rejected frame stays idle", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic [1:0] id;
    int         t;
    int         kind;
    logic [3:0] a;
    logic       bu;
    int         n;

    resetn = 1'b0;
    bus.control = 1'b0; bus.wD = 1'b0; bus.valid = 1'b0; bus.last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", bus.ready, 1);
    check("reset rvalid", bus.rvalid, 0);
    check("reset rD", bus.rD, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single write then read back
    wbuf[0] = 8'hA5;
    do_write(4'd5, 1'b0, 1, -1, 0, 1'b0);
    do_read(4'd5, 1'b0, 1, 0);

    // Id and start-pattern mismatches
    do_reject(3'b111, 2'd1, 1'b0, 4'd0);
    do_reject(3'b110, 2'd2, 1'b1, 4'd0);

    // Burst write wrapping 14,15,0 with a two-cycle stall inside word 2
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(4'd14, 1'b1, 3, DW + 4, 2, 1'b0);
    do_read(4'd0, 1'b0, 1, 0);

    // Burst read stopped by last during word 2
    do_read(4'd14, 1'b1, 2, 3);

    // Reset while the 4th bit of a write word is on the bus
    pat = 8'h5A;
    send_frame(3'b111, 2'd2, 1'b1, 1'b0, 4'd5);
    t = 0;
    while (bus.ready && t < 8) begin @(negedge clk); t++; end
    check("reset-test frame accepted", bus.ready, 0);
    for (int b = 7; b >= 5; b--) begin
      bus.valid = 1'b1; bus.wD = pat[b];
      @(negedge clk);
    end
    bus.valid = 1'b1; bus.wD = pat[4];
    resetn = 1'b0;
    #1;
    check("async reset ready", bus.ready, 1);
    check("async reset rvalid", bus.rvalid, 0);
    check("async reset rD", bus.rD, 0);
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_read(4'd5, 1'b0, 1, 0);

    // Fill the whole RAM so any address can be read back
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    do_write(4'd0, 1'b1, DEPTH, -1, 0, 1'b1);
    do_read(4'd0, 1'b1, 4, 7);

`ifdef SERIAL_SLAVE_PARITY_EN
    // Bad parity drops the write and pulses cfg_err once
    flip_parity = 1'b1;
    send_frame(3'b111, 2'd2, 1'b1, 1'b0, 4'd3);
    flip_parity = 1'b0;
    @(negedge clk);
    check("parity error cfg_err pulse", bus.cfg_err, 1);
    check("parity error ready", bus.ready, 1);
    for (int b = 7; b >= 0; b--) begin
      if (b == 7) check("parity error cfg_err width", bus.cfg_err, 0);
      bus.valid = 1'b1; bus.wD = 1'($urandom);
      @(negedge clk);
    end
    bus.valid = 1'b0;
    do_read(4'd3, 1'b0, 1, 0);
    wbuf[0] = 8'hC3;
    do_write(4'd3, 1'b0, 1, -1, 0, 1'b0);
    check("good parity no cfg_err", bus.cfg_err, 0);
    do_read(4'd3, 1'b0, 1, 0);
`endif

    // Random mix of writes, reads and rejected frames
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      a    = 4'($urandom);
      bu   = 1'($urandom);
      n    = bu ? $urandom_range(1, 4) : 1;
      if (kind == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          do_reject(3'b101, 2'd2, 1'($urandom), a);
        end else begin
          id = 2'($urandom_range(0, 2));
          if (id >= 2'd2) id = id + 2'd1;
          do_reject(3'b111, id, 1'($urandom), a);
        end
      end else if (kind <= 4) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(a, bu, n, -1, 0, 1'b1);
      end else begin
        do_read(a, bu, n, $urandom_range(1, 7));
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
